// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard-side transmitter.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  // Wire order of one frame, bit 0 first: start, data LSB-first, odd parity, stop.
  function automatic logic [10:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ascii_keycode.sv
// ASCII to PS/2 Set-2 make-code lookup; uppercase folds onto lowercase.
module ascii_keycode (
  input  logic [7:0] ascii,
  output logic [7:0] code,
  output logic       hit
);
  logic [7:0] lc;

  always_comb begin
    lc   = (ascii >= 8'h41 && ascii <= 8'h5A) ? (ascii | 8'h20) : ascii;
    code = 8'h00;
    hit  = 1'b1;
    case (lc)
      8'h31: code = 8'h16;  8'h32: code = 8'h1E;  8'h33: code = 8'h26;
      8'h34: code = 8'h25;  8'h35: code = 8'h2E;  8'h36: code = 8'h36;
      8'h37: code = 8'h3D;  8'h38: code = 8'h3E;  8'h39: code = 8'h46;
      8'h30: code = 8'h45;
      8'h61: code = 8'h1C;  8'h62: code = 8'h32;  8'h63: code = 8'h21;
      8'h64: code = 8'h23;  8'h65: code = 8'h24;  8'h66: code = 8'h2B;
      8'h67: code = 8'h34;  8'h68: code = 8'h33;  8'h69: code = 8'h43;
      8'h6A: code = 8'h3B;  8'h6B: code = 8'h42;  8'h6C: code = 8'h4B;
      8'h6D: code = 8'h3A;  8'h6E: code = 8'h31;  8'h6F: code = 8'h44;
      8'h70: code = 8'h4D;  8'h71: code = 8'h15;  8'h72: code = 8'h2D;
      8'h73: code = 8'h1B;  8'h74: code = 8'h2C;  8'h75: code = 8'h3C;
      8'h76: code = 8'h2A;  8'h77: code = 8'h1D;  8'h78: code = 8'h22;
      8'h79: code = 8'h35;  8'h7A: code = 8'h1A;
      8'h5B: code = 8'h54;  8'h5D: code = 8'h5B;  8'h3B: code = 8'h4C;
      8'h27: code = 8'h52;  8'h2C: code = 8'h41;  8'h2E: code = 8'h49;
      8'h2F: code = 8'h4A;  8'h5C: code = 8'h5D;  8'h2D: code = 8'h4E;
      8'h3D: code = 8'h55;  8'h60: code = 8'h0E;
      8'h20: code = 8'h29;  8'h0D: code = 8'h5A;  8'h09: code = 8'h0D;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ascii_ps2_tx.sv
// PS/2 device-side transmitter: one ASCII key in, make + break (F0, code) frames out.
module ascii_ps2_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int GAP_CYC = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_ascii,
  output logic       unmapped,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data
);
  localparam int              DIV_MAX  = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int              DW       = $clog2(DIV_MAX);
  localparam logic [DW-1:0]   HALF_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]   GAP_END  = DW'(GAP_CYC - 1);
  localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  state_t        state, state_n;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    code_q, map_code, frame_byte;
  logic [10:0]   frame;
  logic [9:0]    shreg;
  logic          map_hit, accept, load, shift;

  ascii_keycode u_map (
    .ascii (in_ascii),
    .code  (map_code),
    .hit   (map_hit)
  );

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign ps2_clk  = (state != BIT_LO);
  assign accept   = in_valid && in_ready;

  // Byte 0 comes straight from the mapper; bytes 1 and 2 are F0 then the latched code.
  assign frame_byte = (state == IDLE)     ? map_code  :
                      (byte_cnt == 2'd0)  ? PS2_BREAK : code_q;
  assign frame      = ps2_frame(frame_byte);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      IDLE:   if (accept && map_hit) begin
                state_n = BIT_HI;
                load    = 1'b1;
              end
      BIT_HI: if (div_cnt == HALF_END) state_n = BIT_LO;
      BIT_LO: if (div_cnt == HALF_END) begin
                if (bit_cnt == LAST_BIT) state_n = GAP;
                else begin
                  state_n = BIT_HI;
                  shift   = 1'b1;
                end
              end
      GAP:    if (div_cnt == GAP_END) begin
                if (byte_cnt == 2'd2) state_n = IDLE;
                else begin
                  state_n = BIT_HI;
                  load    = 1'b1;
                end
              end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      code_q   <= '0;
      shreg    <= '1;
      ps2_data <= 1'b1;
      unmapped <= 1'b0;
    end else begin
      state    <= state_n;
      unmapped <= accept && !map_hit;
      div_cnt  <= (state_n != state || state == IDLE) ? '0 : div_cnt + 1'b1;
      if (accept) code_q <= map_code;
      // ps2_data only moves on entry to BIT_HI, so it is flat through the low phase.
      if (load) begin
        ps2_data <= frame[0];
        shreg    <= frame[10:1];
        bit_cnt  <= '0;
        byte_cnt <= (state == IDLE) ? 2'd0 : byte_cnt + 2'd1;
      end else if (shift) begin
        ps2_data <= shreg[0];
        shreg    <= {1'b1, shreg[9:1]};
        bit_cnt  <= bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ascii_ps2_tx.sv
// Scoreboard bench: expected scancodes queued at stimulus, checked at each captured frame.
module tb_ascii_ps2_tx;
  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 8;
  localparam int SEQ_CYC = 3 * (22 * CLK_DIV + GAP_CYC);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_ascii = 8'h00;
  logic       in_ready, unmapped, busy, ps2_clk, ps2_data;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  int         falls = 0, frames = 0, nbits = 0, cyc = 0, last_fall = 0;
  logic       prev_clk = 1'b1, cur_bit = 1'b1;
  logic [10:0] frm = '0;
  logic [7:0] e;

  always #5 clock = ~clock;

  ascii_ps2_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ascii (in_ascii),
    .unmapped (unmapped),
    .busy     (busy),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Host-side receiver: samples data on each falling ps2_clk edge.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      nbits    = 0;
      prev_clk = 1'b1;
    end else begin
      chk("busy", busy, !in_ready);
      if (prev_clk && !ps2_clk) begin
        if (nbits > 0) chk("bit_period", cyc - last_fall, 2 * CLK_DIV);
        last_fall = cyc;
        falls++;
        cur_bit = ps2_data;
        frm = {ps2_data, frm[10:1]};
        nbits++;
        if (nbits == 11) begin
          nbits = 0;
          frames++;
          chk("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("frame", frm, {1'b1, ~^e, e, 1'b0});
          end
        end
      end else if (!prev_clk && !ps2_clk) begin
        chk("data_stable", ps2_data, cur_bit);
      end
      prev_clk = ps2_clk;
    end
  end

  task automatic push_key(input logic [7:0] code);
    exp_q.push_back(code);
    exp_q.push_back(8'hF0);
    exp_q.push_back(code);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] code, input bit mapped);
    int t = 0;
    while (!in_ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    chk("ready_wait", t < 2000, 1);
    in_valid = 1'b1;
    in_ascii = a;
    if (mapped) push_key(code);
    @(negedge clock);
    in_valid = 1'b0;
    chk("first_clk", ps2_clk, 1);
    if (mapped) begin
      chk("start_bit", ps2_data, 0);
      chk("no_unmapped", unmapped, 0);
    end else begin
      chk("unmapped_pulse", unmapped, 1);
      chk("unmapped_ready", in_ready, 1);
      chk("unmapped_data", ps2_data, 1);
      @(negedge clock);
      chk("unmapped_one_cycle", unmapped, 0);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!in_ready && t < 5000) begin
      @(negedge clock);
      t++;
    end
    chk("idle_wait", t < 5000, 1);
    repeat (4) @(negedge clock);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int t;
    int f0;
    bit ok;

    // 1: reset and idle
    @(negedge clock);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_unmapped", unmapped, 0);
    chk("rst_clk", ps2_clk, 1);
    chk("rst_data", ps2_data, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clock);
      ok &= ps2_clk & ps2_data & in_ready & ~unmapped;
    end
    chk("idle_lines", ok, 1);

    // 2: 'a' -> 1C F0 1C, busy for exactly one sequence
    send(8'h61, 8'h1C, 1'b1);
    t = 0;
    while (!in_ready && t < 1000) begin
      t++;
      @(negedge clock);
    end
    chk("ready_low_cycles", t, SEQ_CYC);
    wait_idle();

    // 3: '1' then 'A' with in_valid held high across the busy window
    in_valid = 1'b1;
    in_ascii = 8'h31;
    push_key(8'h16);
    @(negedge clock);
    in_ascii = 8'h41;
    t = 0;
    while (!in_ready && t < 1000) begin
      @(negedge clock);
      t++;
    end
    chk("b2b_ready_low", t, SEQ_CYC);
    push_key(8'h1C);
    @(negedge clock);
    in_valid = 1'b0;
    chk("b2b_accept", in_ready, 0);
    chk("b2b_start", ps2_data, 0);
    wait_idle();

    // 4: unmapped byte
    f0 = falls;
    send(8'h7F, 8'h00, 1'b0);
    repeat (20) @(negedge clock);
    chk("unmapped_no_edge", falls, f0);
    chk("unmapped_stay_ready", in_ready, 1);

    // 5: reset in the middle of the F0 frame of 'z'
    f0 = frames;
    send(8'h7A, 8'h1A, 1'b1);
    t = 0;
    while (!(frames == f0 + 1 && nbits == 5) && t < 2000) begin
      @(negedge clock);
      #2;
      t++;
    end
    chk("midframe_reach", t < 2000, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_clk", ps2_clk, 1);
    chk("mid_rst_data", ps2_data, 1);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send(8'h0D, 8'h5A, 1'b1);
    wait_idle();

    // 6: in_valid pulse while busy is ignored
    f0 = frames;
    send(8'h73, 8'h1B, 1'b1);
    repeat (30) @(negedge clock);
    in_valid = 1'b1;
    in_ascii = 8'h71;
    @(negedge clock);
    in_valid = 1'b0;
    wait_idle();
    repeat (100) @(negedge clock);
    chk("ignored_frames", frames - f0, 3);
    chk("ignored_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
